ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single-port data RAM between two bus masters: requester 0 (CPU control unit, LDS/STS path) and requester 1 (DMA/debug port).
- Serialises single-byte read/write transactions through a req/ack handshake with round-robin or fixed-priority arbitration.
- Supports an optional bounded lock for atomic back-to-back sequences such as read-modify-write.
- Sits between the masters and the ram instance and owns the RAM address, data_in and write_enable signals.

Parameters:
- ADDR_WIDTH, 8, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- RD_LATENCY, 1, clock cycles from the RAM address being driven to valid data_out; legal range 1..4.
- FIXED_PRIORITY, 0: 0 selects round-robin; 1 makes requester 0 always win a contested cycle.
- LOCK_MAX, 4, maximum consecutive grants to a locking requester before a forced release; legal range 1..15.

Ports:
- clock  in  1  system clock (50 MHz)
- reset_s2  in  1  asynchronous, active-high reset
- req0, req1  in  1 each  transaction request; held until ack
- we0, we1  in  1 each  1 = write, 0 = read
- lock0, lock1  in  1 each  keep the grant for the next transaction
- addr0, addr1  in  ADDR_WIDTH each  byte address
- wdata0, wdata1  in  DATA_WIDTH each  write data
- ack0, ack1  out  1 each  single-cycle completion pulse
- rdata0, rdata1  out  DATA_WIDTH each  read data; valid with ack, held until that requester's next read ack
- mem_address  out  ADDR_WIDTH  to ram.address
- mem_data_in  out  DATA_WIDTH  to ram.data_in
- mem_write_enable  out  1  to ram.write_enable
- mem_data_out  in  DATA_WIDTH  from ram.data_out
- busy  out  1  high in any state other than IDLE
- grant_id  out  1  requester currently or last served

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; all outputs = 0.
  - round-robin pointer = 0 (requester 0 preferred); lock counter = 0.
  - Asserting reset mid-transaction aborts it immediately: mem_write_enable drops, no ack is issued, and a partial write is not committed beyond any clock edge that has already occurred.
- FSM: IDLE -> ACCESS -> (WAIT, reads only) -> DONE -> IDLE. All outputs are registered.
- IDLE:
  - Sample req0/req1.
  - With no request, stay in IDLE.
  - With one request, grant it.
  - With both requesting: if a lock is active, grant the lock owner; else if FIXED_PRIORITY = 1, grant 0; else grant the pointer's requester.
  - On grant, capture we, addr and wdata into internal registers, set grant_id, and go to ACCESS.
- ACCESS (1 cycle):
  - mem_address and mem_data_in = captured values.
  - mem_write_enable = captured we.
  - Write goes to DONE; read goes to WAIT.
- WAIT: RD_LATENCY cycles. On the final WAIT edge, capture mem_data_out into rdata of the granted requester, then go to DONE.
- DONE (1 cycle):
  - ack of the granted requester = 1; mem_write_enable = 0.
  - Pointer moves to the other requester (round-robin mode).
  - Lock handling:
    - If the granted lock is high and lock counter + 1 < LOCK_MAX: lock becomes active with that owner and the counter increments.
    - Otherwise the lock clears and the counter is 0.
  - Next state is IDLE.
- Latency, req sampled high in IDLE at cycle 0: write commits at the end of cycle 1 and ack is high in cycle 2. Read ack is high in cycle 2 + RD_LATENCY (cycle 3 at default).
- Throughput: one write per 3 cycles; one read per 3 + RD_LATENCY cycles.
- Requester rules:
  - Keep req high until ack is seen; drop req on the edge that samples ack.
  - req still high in the IDLE after DONE counts as a new request.
  - Input changes after the grant are ignored; the captured values are used.
  - Dropping req before it is granted means it is not served. Dropping it after the grant still lets the transaction complete and ack pulse.
- Lock rules:
  - While a lock is active, the non-owner is not granted while the owner requests.
  - If the owner does not request in IDLE, the lock clears and normal arbitration applies in that same cycle.
  - Forced release at LOCK_MAX guarantees the other requester is served within LOCK_MAX+1 transactions.
- Address and data pass through unchanged; there is no wrap or arithmetic. Counters saturate and never wrap.
- rdata of the non-granted requester never changes.

Decomposition:
- Package def additions:
  - typedef enum arb_state {ARB_IDLE, ARB_ACCESS, ARB_WAIT, ARB_DONE}.
  - Constants REQ_CPU = 0 and REQ_DMA = 1.
  - typedef struct arb_request {we, address, data}.
- One sub-module, arb_select: the registered round-robin pointer, lock owner and counter, plus the combinational winner selection, with a grant-taken strobe input from the FSM.

Test Plan:
- req0 write addr 0x10 data 0xA5 from reset -> mem_write_enable high only in cycle 1 with address 0x10; ack0 in cycle 2; a later read of 0x10 gives rdata0 = 0xA5 with ack0 in cycle 3.
- req0 and req1 both held with reads to 0x20/0x21, round-robin -> grants alternate 0, 1, 0, 1; grant_id follows; each ack matches its requester's data.
- FIXED_PRIORITY = 1 with both requesting continuously -> only requester 0 is served and ack1 never pulses.
- lock1 held high with LOCK_MAX = 4 and req0 waiting -> four consecutive requester-1 grants, then requester 0 is granted.
- Reset asserted during ACCESS of a write to 0x30 -> all outputs 0 immediately; no ack; state IDLE after release.
- RD_LATENCY = 3 read -> ack in cycle 5 with rdata equal to the RAM contents; busy high in cycles 1 through 5.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared types and constants for the data RAM arbiter
package ram_arbiter_pkg;

  // Widths of the captured request; the top's ADDR_WIDTH/DATA_WIDTH must match these.
  localparam int ARB_ADDR_WIDTH = 8;
  localparam int ARB_DATA_WIDTH = 8;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_WAIT,
    ARB_DONE
  } arb_state;

  typedef struct packed {
    logic                      we;
    logic [ARB_ADDR_WIDTH-1:0] address;
    logic [ARB_DATA_WIDTH-1:0] data;
  } arb_request;

  // The requester that is not `id`; used to hand the round-robin turn over.
  function automatic logic other_req(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/ram_arbiter_arb_select.sv
// rtl/ram_arbiter_arb_select.sv - round-robin pointer, bounded lock and winner selection
module arb_select
  import ram_arbiter_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0,
  parameter int LOCK_MAX       = 4
) (
  input  logic clock,
  input  logic reset_s2,
  input  logic req0,
  input  logic req1,
  input  logic idle,
  input  logic taken,
  input  logic taken_id,
  input  logic taken_lock,
  output logic winner_valid,
  output logic winner_id
);

  logic       ptr;
  logic       lock_active;
  logic       lock_owner;
  logic [3:0] lock_count;
  logic       owner_req;
  logic       lock_extend;

  // Winner: an active lock whose owner is still asking beats everything else.
  always_comb begin
    owner_req    = lock_owner ? req1 : req0;
    winner_valid = req0 | req1;
    lock_extend  = taken_lock && ((5'(lock_count) + 5'd1) < 5'(LOCK_MAX));
    if (lock_active && owner_req) begin
      winner_id = lock_owner;
    end else if (req0 && req1) begin
      winner_id = (FIXED_PRIORITY != 0) ? REQ_CPU : ptr;
    end else begin
      winner_id = req1 ? REQ_DMA : REQ_CPU;
    end
  end

  // Pointer and lock bookkeeping: updated when a transaction completes, and the
  // lock is dropped in IDLE as soon as its owner stops asking.
  always_ff @(posedge clock or posedge reset_s2) begin
    if (reset_s2) begin
      ptr         <= REQ_CPU;
      lock_active <= 1'b0;
      lock_owner  <= REQ_CPU;
      lock_count  <= 4'd0;
    end else if (taken) begin
      ptr <= other_req(taken_id);
      if (lock_extend) begin
        lock_active <= 1'b1;
        lock_owner  <= taken_id;
        lock_count  <= lock_count + 4'd1;
      end else begin
        lock_active <= 1'b0;
        lock_count  <= 4'd0;
      end
    end else if (idle && lock_active && !owner_req) begin
      lock_active <= 1'b0;
      lock_count  <= 4'd0;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-master single-port data RAM arbiter with req/ack handshake
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int RD_LATENCY     = 1,
  parameter int FIXED_PRIORITY = 0,
  parameter int LOCK_MAX       = 4
) (
  input  logic                  clock,
  input  logic                  reset_s2,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  busy,
  output logic                  grant_id
);

  localparam logic [2:0] WAIT_LAST = 3'(RD_LATENCY - 1);

  arb_state   state;
  arb_request cap;
  arb_request sel_req;
  logic       cap_lock;
  logic [2:0] wait_count;
  logic       winner_valid;
  logic       winner_id;
  logic       in_idle;
  logic       in_done;

  assign in_idle     = (state == ARB_IDLE);
  assign in_done     = (state == ARB_DONE);
  assign mem_address = ADDR_WIDTH'(cap.address);
  assign mem_data_in = DATA_WIDTH'(cap.data);

  arb_select #(
    .FIXED_PRIORITY (FIXED_PRIORITY),
    .LOCK_MAX       (LOCK_MAX)
  ) u_select (
    .clock        (clock),
    .reset_s2     (reset_s2),
    .req0         (req0),
    .req1         (req1),
    .idle         (in_idle),
    .taken        (in_done),
    .taken_id     (grant_id),
    .taken_lock   (cap_lock),
    .winner_valid (winner_valid),
    .winner_id    (winner_id)
  );

  // Request presented by the current winner, ready to be captured on grant.
  always_comb begin
    sel_req.we      = winner_id ? we1 : we0;
    sel_req.address = ARB_ADDR_WIDTH'(winner_id ? addr1 : addr0);
    sel_req.data    = ARB_DATA_WIDTH'(winner_id ? wdata1 : wdata0);
  end

  // Transaction FSM; the captured request drives the RAM pins directly so the
  // address is on the bus in the first ACCESS cycle.
  always_ff @(posedge clock or posedge reset_s2) begin
    if (reset_s2) begin
      state            <= ARB_IDLE;
      cap              <= '0;
      cap_lock         <= 1'b0;
      wait_count       <= 3'd0;
      ack0             <= 1'b0;
      ack1             <= 1'b0;
      rdata0           <= '0;
      rdata1           <= '0;
      mem_write_enable <= 1'b0;
      busy             <= 1'b0;
      grant_id         <= REQ_CPU;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (winner_valid) begin
            cap              <= sel_req;
            cap_lock         <= winner_id ? lock1 : lock0;
            grant_id         <= winner_id;
            mem_write_enable <= sel_req.we;
            busy             <= 1'b1;
            state            <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          mem_write_enable <= 1'b0;
          wait_count       <= 3'd0;
          if (cap.we) begin
            ack0  <= (grant_id == REQ_CPU);
            ack1  <= (grant_id == REQ_DMA);
            state <= ARB_DONE;
          end else begin
            state <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (wait_count == WAIT_LAST) begin
            if (grant_id == REQ_DMA) begin
              rdata1 <= mem_data_out;
              ack1   <= 1'b1;
            end else begin
              rdata0 <= mem_data_out;
              ack0   <= 1'b1;
            end
            state <= ARB_DONE;
          end else begin
            wait_count <= wait_count + 3'd1;
          end
        end
        ARB_DONE: begin
          ack0             <= 1'b0;
          ack1             <= 1'b0;
          mem_write_enable <= 1'b0;
          busy             <= 1'b0;
          state            <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter
module tb_ram_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_s2;
  logic       req0, req1, we0, we1, lock0, lock1;
  logic [7:0] addr0, addr1, wdata0, wdata1;

  logic       ack0_a, ack1_a, busy_a, grant_a, mwe_a;
  logic [7:0] rdata0_a, rdata1_a, maddr_a, mdin_a, mdout_a;
  logic       ack0_f, ack1_f, busy_f, grant_f, mwe_f;
  logic [7:0] rdata0_f, rdata1_f, maddr_f, mdin_f, mdout_f;
  logic       ack0_l, ack1_l, busy_l, grant_l, mwe_l;
  logic [7:0] rdata0_l, rdata1_l, maddr_l, mdin_l, mdout_l;

  logic       pre_en;
  logic [7:0] pre_addr, pre_data;
  logic [7:0] ram_a [256];
  logic [7:0] ram_f [256];
  logic [7:0] ram_l [256];
  logic [7:0] pipe_l [3];

  int checks = 0;
  int errors = 0;

  ram_arbiter dut_a (
    .clock(clock), .reset_s2(reset_s2), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0_a), .ack1(ack1_a), .rdata0(rdata0_a), .rdata1(rdata1_a), .mem_address(maddr_a),
    .mem_data_in(mdin_a), .mem_write_enable(mwe_a), .mem_data_out(mdout_a), .busy(busy_a),
    .grant_id(grant_a)
  );

  ram_arbiter #(.FIXED_PRIORITY(1)) dut_f (
    .clock(clock), .reset_s2(reset_s2), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0_f), .ack1(ack1_f), .rdata0(rdata0_f), .rdata1(rdata1_f), .mem_address(maddr_f),
    .mem_data_in(mdin_f), .mem_write_enable(mwe_f), .mem_data_out(mdout_f), .busy(busy_f),
    .grant_id(grant_f)
  );

  ram_arbiter #(.RD_LATENCY(3)) dut_l (
    .clock(clock), .reset_s2(reset_s2), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0_l), .ack1(ack1_l), .rdata0(rdata0_l), .rdata1(rdata1_l), .mem_address(maddr_l),
    .mem_data_in(mdin_l), .mem_write_enable(mwe_l), .mem_data_out(mdout_l), .busy(busy_l),
    .grant_id(grant_l)
  );

  // RAM models: one registered read stage for the default DUTs, three for dut_l.
  always @(posedge clock) begin
    if (pre_en) begin
      ram_a[pre_addr] <= pre_data;
      ram_f[pre_addr] <= pre_data;
      ram_l[pre_addr] <= pre_data;
    end else begin
      if (mwe_a) ram_a[maddr_a] <= mdin_a;
      if (mwe_f) ram_f[maddr_f] <= mdin_f;
      if (mwe_l) ram_l[maddr_l] <= mdin_l;
    end
    mdout_a   <= ram_a[maddr_a];
    mdout_f   <= ram_f[maddr_f];
    pipe_l[0] <= ram_l[maddr_l];
    pipe_l[1] <= pipe_l[0];
    pipe_l[2] <= pipe_l[1];
  end
  assign mdout_l = pipe_l[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset_s2 = 1;
    tick();
    tick();
    reset_s2 = 0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_en = 1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int n0;
    int n1;
    pre_en = 0; pre_addr = 0; pre_data = 0;
    idle_inputs();
    reset_s2 = 1;
    preload(8'h20, 8'h3C);
    preload(8'h21, 8'hC3);
    preload(8'h30, 8'h00);
    preload(8'h55, 8'h9E);

    // Reset state
    check("rst_ack0", ack0_a, 0);
    check("rst_ack1", ack1_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_we", mwe_a, 0);
    check("rst_addr", maddr_a, 0);
    check("rst_grant", grant_a, 0);
    check("rst_rdata0", rdata0_a, 0);

    // Write 0xA5 to 0x10 from requester 0
    do_reset();
    req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 8'hA5;
    tick();
    check("wr_c1_we", mwe_a, 1);
    check("wr_c1_addr", maddr_a, 8'h10);
    check("wr_c1_din", mdin_a, 8'hA5);
    check("wr_c1_busy", busy_a, 1);
    check("wr_c1_ack0", ack0_a, 0);
    tick();
    check("wr_c2_ack0", ack0_a, 1);
    check("wr_c2_we", mwe_a, 0);
    check("wr_c2_ack1", ack1_a, 0);
    req0 = 0; we0 = 0;
    tick();
    check("wr_c3_ack0", ack0_a, 0);
    check("wr_c3_busy", busy_a, 0);
    check("wr_ram", ram_a[8'h10], 8'hA5);

    // Read back 0x10
    req0 = 1; we0 = 0; addr0 = 8'h10;
    tick();
    check("rd_c1_we", mwe_a, 0);
    check("rd_c1_addr", maddr_a, 8'h10);
    tick();
    check("rd_c2_ack0", ack0_a, 0);
    tick();
    check("rd_c3_ack0", ack0_a, 1);
    check("rd_c3_rdata0", rdata0_a, 8'hA5);
    check("rd_rdata1_untouched", rdata1_a, 0);
    req0 = 0;
    tick();

    // Round-robin with both requesters reading continuously
    do_reset();
    req0 = 1; addr0 = 8'h20; req1 = 1; addr1 = 8'h21;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin tick(); n++; end while (!(ack0_a | ack1_a) && n < 12);
      check("rr_ack_seen", ack0_a | ack1_a, 1);
      check("rr_ack_id", {ack1_a, ack0_a}, (k % 2) ? 2 : 1);
      check("rr_grant_id", grant_a, k % 2);
      check("rr_rdata", (k % 2) ? rdata1_a : rdata0_a, (k % 2) ? 8'hC3 : 8'h3C);
    end
    idle_inputs();
    tick();

    // Fixed priority: requester 0 always wins
    do_reset();
    req0 = 1; addr0 = 8'h20; req1 = 1; addr1 = 8'h21;
    n0 = 0; n1 = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (ack0_f) n0++;
      if (ack1_f) n1++;
    end
    check("fp_ack0_count", n0, 10);
    check("fp_ack1_count", n1, 0);
    check("fp_rdata0", rdata0_f, 8'h3C);
    idle_inputs();
    tick();

    // Lock: requester 1 holds four grants, then requester 0 gets in
    do_reset();
    req1 = 1; lock1 = 1; we1 = 1; addr1 = 8'h40; wdata1 = 8'h11;
    tick();
    req0 = 1; we0 = 1; addr0 = 8'h41; wdata0 = 8'h22;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      do begin tick(); n++; end while (!(ack0_a | ack1_a) && n < 12);
      check("lock_ack_seen", ack0_a | ack1_a, 1);
      check("lock_ack_id", {ack1_a, ack0_a}, (k == 4) ? 1 : 2);
      if (k == 4) req0 = 0;
    end
    check("lock_ram0", ram_a[8'h41], 8'h22);
    check("lock_ram1", ram_a[8'h40], 8'h11);
    idle_inputs();
    tick();
    tick();

    // Reset during ACCESS of a write
    do_reset();
    req0 = 1; we0 = 1; addr0 = 8'h30; wdata0 = 8'h77;
    tick();
    check("abort_c1_we", mwe_a, 1);
    reset_s2 = 1;
    #1;
    check("abort_we", mwe_a, 0);
    check("abort_addr", maddr_a, 0);
    check("abort_din", mdin_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_ack0", ack0_a, 0);
    req0 = 0; we0 = 0;
    tick();
    reset_s2 = 0;
    tick();
    check("abort_ram", ram_a[8'h30], 8'h00);
    check("abort_idle_busy", busy_a, 0);
    check("abort_idle_ack0", ack0_a, 0);

    // RD_LATENCY = 3 read
    do_reset();
    req0 = 1; we0 = 0; addr0 = 8'h55;
    for (int c = 1; c <= 6; c++) begin
      tick();
      check("lat3_busy", busy_l, (c <= 5) ? 1 : 0);
      check("lat3_ack0", ack0_l, (c == 5) ? 1 : 0);
      if (c == 5) begin
        check("lat3_rdata0", rdata0_l, 8'h9E);
        req0 = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
